// File: rtl/ru_fault_scheduler.sv
// ru_fault_scheduler: scans the BIST pass map, assigns faulty PEs to recompute-unit slots,
// then steps all assigned slots in lockstep through COLS recompute steps.
module ru_fault_scheduler #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int NUM_RU = 4,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int IW = $clog2(ROWS * COLS),
  localparam int FW = $clog2(ROWS * COLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   stw_result,
  input  logic                   step_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   unrepairable,
  output logic [FW-1:0]          fault_count,
  output logic [NUM_RU-1:0]      ru_valid,
  output logic [NUM_RU*RW-1:0]   ru_row,
  output logic [NUM_RU*CW-1:0]   ru_col,
  output logic                   step_valid,
  output logic [CW-1:0]          step_k
);
  typedef enum logic [1:0] {IDLE, SCAN, RUN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [ROWS*COLS-1:0]   pass_q, pass_d;
  logic [RW-1:0]          r_q, r_d;
  logic [CW-1:0]          c_q, c_d;
  logic                   busy_q, busy_d, done_q, done_d, unrep_q, unrep_d;
  logic [FW-1:0]          fault_count_q, fault_count_d;
  logic [NUM_RU-1:0]      ru_valid_q, ru_valid_d;
  logic [NUM_RU*RW-1:0]   ru_row_q, ru_row_d;
  logic [NUM_RU*CW-1:0]   ru_col_q, ru_col_d;
  logic                   step_valid_q, step_valid_d;
  logic [CW-1:0]          step_k_q, step_k_d;
  logic [IW-1:0]          idx;
  logic                   row_end, last;
  assign idx     = IW'(int'(r_q) * COLS + int'(c_q));
  assign row_end = c_q == CW'(COLS - 1);
  assign last    = row_end && r_q == RW'(ROWS - 1);
  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    r_d           = r_q;
    c_d           = c_q;
    unrep_d       = unrep_q;
    fault_count_d = fault_count_q;
    ru_valid_d    = ru_valid_q;
    ru_row_d      = ru_row_q;
    ru_col_d      = ru_col_q;
    step_k_d      = step_k_q;
    case (state_q)
      IDLE: if (start) begin
        state_d       = SCAN;
        pass_d        = stw_result;
        r_d           = '0;
        c_d           = '0;
        unrep_d       = 1'b0;
        fault_count_d = '0;
        ru_valid_d    = '0;
        ru_row_d      = '0;
        ru_col_d      = '0;
        step_k_d      = '0;
      end
      SCAN: begin
        if (!pass_q[idx]) begin
          // The first NUM_RU faults land in slots 0..NUM_RU-1; any further fault is unrepairable.
          for (int n = 0; n < NUM_RU; n++)
            if (int'(fault_count_q) == n) begin
              ru_valid_d[n]        = 1'b1;
              ru_row_d[n*RW +: RW] = r_q;
              ru_col_d[n*CW +: CW] = c_q;
            end
          unrep_d       = unrep_q | (int'(fault_count_q) >= NUM_RU);
          fault_count_d = fault_count_q + FW'(1);
        end
        c_d = row_end ? '0 : c_q + CW'(1);
        r_d = row_end ? r_q + RW'(1) : r_q;
        if (last) begin
          state_d  = (fault_count_d == '0 || unrep_d) ? DONE : RUN;
          step_k_d = '0;
        end
      end
      RUN: if (step_ready) begin
        state_d  = step_k_q == CW'(COLS - 1) ? DONE : RUN;
        step_k_d = step_k_q == CW'(COLS - 1) ? step_k_q : step_k_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d       = state_d != IDLE;
    done_d       = state_d == DONE;
    step_valid_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pass_q        <= '0;
      r_q           <= '0;
      c_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      unrep_q       <= 1'b0;
      fault_count_q <= '0;
      ru_valid_q    <= '0;
      ru_row_q      <= '0;
      ru_col_q      <= '0;
      step_valid_q  <= 1'b0;
      step_k_q      <= '0;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      r_q           <= r_d;
      c_q           <= c_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      unrep_q       <= unrep_d;
      fault_count_q <= fault_count_d;
      ru_valid_q    <= ru_valid_d;
      ru_row_q      <= ru_row_d;
      ru_col_q      <= ru_col_d;
      step_valid_q  <= step_valid_d;
      step_k_q      <= step_k_d;
    end
  end
  assign busy         = busy_q;
  assign done         = done_q;
  assign unrepairable = unrep_q;
  assign fault_count  = fault_count_q;
  assign ru_valid     = ru_valid_q;
  assign ru_row       = ru_row_q;
  assign ru_col       = ru_col_q;
  assign step_valid   = step_valid_q;
  assign step_k       = step_k_q;
endmodule

// File: tb/tb_ru_fault_scheduler.sv
// tb_ru_fault_scheduler: directed and randomized pass maps checked against a fault-list model.
module tb_ru_fault_scheduler;
  localparam int ROWS = 4, COLS = 4, NUM_RU = 4, N = ROWS * COLS;
  localparam int RW = 2, CW = 2, FW = 5;
  logic clk = 0, rst = 0, start = 0, step_ready = 0;
  logic [N-1:0] stw_result = '0;
  logic busy, done, unrepairable, step_valid;
  logic [FW-1:0] fault_count;
  logic [NUM_RU-1:0] ru_valid;
  logic [NUM_RU*RW-1:0] ru_row;
  logic [NUM_RU*CW-1:0] ru_col;
  logic [CW-1:0] step_k;
  int checks = 0, failures = 0;
  ru_fault_scheduler #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU)) dut (
    .clk(clk), .rst(rst), .start(start), .stw_result(stw_result), .step_ready(step_ready),
    .busy(busy), .done(done), .unrepairable(unrepairable), .fault_count(fault_count),
    .ru_valid(ru_valid), .ru_row(ru_row), .ru_col(ru_col), .step_valid(step_valid), .step_k(step_k)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] all_out();
    return 64'({busy, done, unrepairable, fault_count, ru_valid, ru_row, ru_col, step_valid, step_k});
  endfunction
  // mode 0: step_ready always 1; mode 1: three stall cycles at step_k=1; mode 2: random ready
  task automatic run_case(input logic [N-1:0] pm, input int mode);
    int faults[$];
    logic [NUM_RU-1:0] ev;
    logic [NUM_RU*RW-1:0] er;
    logic [NUM_RU*CW-1:0] ec;
    int k, stalls;
    bit skip, rdy, fin;
    ev = '0; er = '0; ec = '0; k = 0; stalls = 0; fin = 0;
    for (int i = 0; i < N; i++) if (!pm[i]) faults.push_back(i);
    for (int n = 0; n < faults.size() && n < NUM_RU; n++) begin
      ev[n] = 1'b1;
      er[n*RW +: RW] = RW'(faults[n] / COLS);
      ec[n*CW +: CW] = CW'(faults[n] % COLS);
    end
    skip = faults.size() == 0 || faults.size() > NUM_RU;
    @(negedge clk); stw_result = pm; start = 1; step_ready = 0;
    @(negedge clk); start = 0; stw_result = N'($urandom);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_cleared", 64'({fault_count, ru_valid, unrepairable, done}), 0);
    for (int c = 2; c <= N; c++) begin
      @(negedge clk);
      chk("scan_busy_done_sv", 64'({busy, done, step_valid}), 64'(3'b100));
      start = (c == 5);
    end
    @(negedge clk); start = 0;
    chk("fault_count", 64'(fault_count), 64'(faults.size()));
    chk("unrepairable", 64'(unrepairable), 64'(faults.size() > NUM_RU));
    chk("ru_valid", 64'(ru_valid), 64'(ev));
    chk("ru_row", 64'(ru_row), 64'(er));
    chk("ru_col", 64'(ru_col), 64'(ec));
    if (!skip) begin
      for (int g = 0; g < 200 && !fin; g++) begin
        chk("run_sv_done", 64'({step_valid, done, busy}), 64'(3'b101));
        chk("step_k", 64'(step_k), 64'(k));
        rdy = mode == 0 ? 1'b1 : mode == 1 ? !(k == 1 && stalls < 3) : ($urandom_range(3) != 0);
        if (!rdy && mode == 1) stalls++;
        step_ready = rdy;
        fin = rdy && k == COLS - 1;
        if (rdy && !fin) k++;
        @(negedge clk); step_ready = 0;
      end
      if (!fin) chk("run_timeout", 0, 1);
    end
    chk("done_cycle", 64'({done, step_valid, busy}), 64'(3'b101));
    start = 1; stw_result = '0;
    @(negedge clk); start = 0;
    chk("after_done_idle", 64'({busy, done, step_valid}), 0);
    chk("held_count", 64'({fault_count, ru_valid}), 64'({FW'(faults.size()), ev}));
  endtask
  task automatic reset_at(input logic [N-1:0] pm, input int when);
    @(negedge clk); stw_result = pm; start = 1; step_ready = 1;
    @(negedge clk); start = 0;
    repeat (when) @(negedge clk);
    #2 rst = 0;
    #1 chk("async_reset_zero", all_out(), 0);
    @(negedge clk);
    chk("reset_held_zero", all_out(), 0);
    rst = 1; step_ready = 0;
  endtask
  initial begin
    logic [N-1:0] pm;
    logic [N-1:0] two;
    repeat (2) @(negedge clk);
    chk("reset_state", all_out(), 0);
    rst = 1;
    two = ~(N'(1) << 6 | N'(1) << 12);
    run_case('1, 0);
    run_case(two, 0);
    run_case(two, 1);
    run_case(~(N'(1) | N'(1) << 3 | N'(1) << 5 | N'(1) << 9 | N'(1) << 15), 0);
    run_case('1, 0);
    reset_at(two, 8);
    run_case(two, 0);
    reset_at(two, 18);
    run_case(two, 2);
    for (int it = 0; it < 40; it++) begin
      pm = '1;
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) pm[i] = 1'b0;
      if (it % 10 == 9) reset_at(pm, $urandom_range(20));
      run_case(pm, (it % 3 == 0) ? 0 : 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ru_fault_scheduler.md
# ru_fault_scheduler

Sequencer placed between the STW (BIST) result matrix and the recompute units (RUs) of the systolic array. After a test completes, it scans the pass/fail matrix one PE per cycle and assigns up to NUM_RU faulty PEs to RU slots. It flags the array as unrepairable when there are more faults than slots. It then steps all assigned RUs in lockstep through COLS recompute steps using a valid/ready handshake with the datapath.

## Interface
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥2)
- NUM_RU, 4, recompute unit slots (≥1)
- Derived: RW=$clog2(ROWS), CW=$clog2(COLS), IW=$clog2(ROWS*COLS), FW=$clog2(ROWS*COLS+1)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to capture `stw_result` and begin; ignored while `busy`
- stw_result  in  ROWS*COLS  PE pass map; bit r*COLS+c is PE(r,c); 1=pass, 0=faulty
- step_ready  in  1  datapath accepts the current recompute step
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- unrepairable  out  1  fault count exceeded NUM_RU; sticky until next accepted `start`
- fault_count  out  FW  total faulty PEs found in last scan (saturates only at ROWS*COLS)
- ru_valid  out  NUM_RU  bit n = slot n holds a faulty PE
- ru_row  out  NUM_RU*RW  slot n row at bits [n*RW +: RW]
- ru_col  out  NUM_RU*CW  slot n column at bits [n*CW +: CW]
- step_valid  out  1  recompute step k is presented
- step_k  out  CW  current recompute index (data column / weight row to use)

## Operation
- States: IDLE, SCAN, RUN, DONE.
- IDLE, `start`=1: latch `stw_result`. Clear `ru_valid`, `fault_count`, `unrepairable`. Scan index = 0. Go to SCAN.
- SCAN: examine one PE per cycle in row-major order (index 0 .. ROWS*COLS-1). A PE is faulty when its latched bit = 0.
- For each faulty PE:
  - if `fault_count` < NUM_RU before the increment, write its (r,c) into slot `fault_count` and set its `ru_valid` bit;
  - otherwise set `unrepairable`;
  - in both cases, `fault_count` += 1.
- Slots therefore fill in ascending order with the first NUM_RU faults in row-major order.
- After the last index:
  - `fault_count`=0 or `unrepairable`=1: go to DONE (RUN is skipped);
  - otherwise go to RUN with `step_k`=0.
- RUN: `step_valid`=1. On a cycle with `step_ready`=1:
  - `step_k`=COLS-1: go to DONE;
  - otherwise `step_k` += 1.
- All valid slots share `step_k`; the datapath forms operands from `ru_row`/`ru_col`/`step_k`.
- `step_ready`=0 holds `step_k` and `step_valid` stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `ru_valid`, `ru_row`, `ru_col`, `fault_count` and `unrepairable` hold their values in IDLE until the next accepted `start`.
- Unused slots read row=0, col=0 with `ru_valid` bit 0.

## Timing
- Reset (async assert, released synchronously to clk): state IDLE; every output 0 (`busy`, `done`, `unrepairable`, `fault_count`, `ru_valid`, `ru_row`, `ru_col`, `step_valid`, `step_k`).
- Reset asserted mid-SCAN or mid-RUN aborts immediately to the same all-zero state; no `done` is issued.
- `start` sampled at edge T:
  - `busy`=1 from T+1;
  - SCAN occupies T+1 .. T+ROWS*COLS;
  - RUN (or DONE) begins at T+ROWS*COLS+1.
- Zero faults, defaults: `done`=1 in cycle T+17, `busy`=0 at T+18.
- Faults ≤ NUM_RU and `step_ready` held 1: RUN lasts COLS cycles; `done` in cycle T+ROWS*COLS+COLS+1 (T+21 at defaults).
- All outputs are registered; `done` and `step_valid` are never high together.
- `start` while `busy`: no effect. `start` in the DONE cycle: ignored.

## Test plan
- Reset check: drive `rst`=0 at random points (IDLE, SCAN, RUN) -> all outputs 0 within the same cycle (async); after release, `start` works normally.
- All-pass (`stw_result`=16'hFFFF): `start` -> `fault_count`=0, `ru_valid`=0, `unrepairable`=0, no `step_valid`, `done` at T+17.
- Two faults, PE(1,2) and PE(3,0) (bits 6 and 12 cleared): `start` with `step_ready`=1 ->
  - slot0=(1,2), slot1=(3,0), `ru_valid`=4'b0011, `fault_count`=2;
  - `step_k` = 0,1,2,3 on T+17..T+20;
  - `done` at T+21.
- Backpressure, same stimulus: hold `step_ready`=0 for 3 cycles at `step_k`=1 -> `step_k` stays 1 with `step_valid`=1, and `done` is delayed by exactly 3 cycles.
- Overflow, five faults at indices 0,3,5,9,15: `start` ->
  - slots = (0,0),(0,3),(1,1),(2,1); `ru_valid`=4'hF;
  - `fault_count`=5, `unrepairable`=1;
  - RUN skipped, `done` at T+17.
- Retrigger: `start` pulsed while `busy` -> ignored. A new `start` after `done` with 16'hFFFF -> `unrepairable`, `ru_valid` and `fault_count` are cleared at T+1.
